cpu_ula_param: RTL
==================

CPU_ULA_PARAM -- requirements
Module: cpu_ula_param

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal values are 8 to 32.
REQ-002 Parameter IMM_W, default 7: immediate field width in src2; bit IMM_W-1 is the sign and bits IMM_W-2:0 are the magnitude.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 op_code  input  4  operation select.
REQ-007 src1, src2  input  WIDTH each  operands; src2 also carries the immediate.
REQ-008 op_result  output  WIDTH  registered result.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 zero, carry, overflow  output  1 each  registered flags.

Function
REQ-012 Op codes SHALL be: ADD=0001, ADDI=0010, SUB=0011, SUBI=0100, MUL=0101, AND=0110, OR=0111, XOR=1000, SHL=1001, SHR=1010; all other codes are illegal.
REQ-013 FSM states SHALL be IDLE, CALC, MULT and FINISH.
REQ-014 In IDLE, start=1 with a legal op SHALL latch src1, src2 and op_code and go to MULT for MUL or to CALC for any other op.
REQ-015 start with an illegal op SHALL be ignored: stay in IDLE, no done.
REQ-016 start while busy=1 SHALL be ignored; latched operands stay stable and are unaffected by input changes.
REQ-017 CALC SHALL register op_result and flags, then go to FINISH.
REQ-018 Non-MUL latency: start sampled at edge k -> done=1 for the cycle after edge k+2.
REQ-019 MULT SHALL use shift-add at one multiplier bit per cycle, run for exactly WIDTH cycles, then go to FINISH.
REQ-020 MUL latency: start sampled at edge k -> done=1 for the cycle after edge k+WIDTH+1.
REQ-021 FINISH SHALL assert done for exactly one cycle, then go to IDLE; a start in FINISH is ignored.
REQ-022 ADDI/SUBI: imm = zero-extended src2[IMM_W-2:0].
- ADDI: src1+imm if the sign bit is 0, else src1-imm.
- SUBI: the inverse of ADDI.
REQ-023 SHL/SHR: logical shift of src1 by src2[$clog2(WIDTH)-1:0].
REQ-024 MUL: op_result = low WIDTH bits of the unsigned product.
REQ-025 zero SHALL be 1 iff the new op_result is 0.
REQ-026 carry SHALL be:
- add-type ops: carry-out.
- sub-type ops: borrow (unsigned src1 < subtrahend).
- SHL: last bit shifted out (0 for a shift of 0).
- all other ops: 0.
REQ-027 overflow SHALL be:
- ADD/SUB/ADDI/SUBI: two's-complement signed overflow.
- MUL: 1 iff the upper WIDTH product bits are nonzero.
- all other ops: 0.
REQ-028 op_result and flags SHALL hold their value until the next completed operation.
REQ-029 All arithmetic wraps modulo 2^WIDTH.

Reset
REQ-030 reset=0 SHALL immediately force IDLE and clear to 0: op_result, zero, carry, overflow, done, busy, and the internal multiplier registers.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse; the next start after release behaves normally.

Verification (WIDTH=16, IMM_W=7)
REQ-032 ADD 0xFFFF+0x0001 -> op_result 0x0000, zero=1, carry=1, overflow=0, done after edge k+2.
REQ-033 SUBI src1=5, src2=0x0043 (negative 3) -> op_result 8; ADD 0x7FFF+1 -> 0x8000, overflow=1.
REQ-034 MUL 300*300 -> op_result 0x5F90, overflow=1; busy for 17 cycles; done after edge k+17.
REQ-035 ADD request pulsed at cycle 5 of a MUL -> ignored; the MUL result is delivered unchanged with a single done.
REQ-036 reset pulsed mid-MUL -> all outputs 0 and no done; then ADD 2+3 -> op_result 5, done after edge k+2.
REQ-037 start with op_code 0000 or 1111 -> busy stays 0, no done, and op_result keeps its previous value.

Source files
------------

// File: rtl/cpu_ula_param.sv
// Parameterised ALU with a start/done handshake. Single-cycle ops go through CALC.
// MUL goes through MULT, a shift-add loop that consumes one multiplier bit per cycle.
module cpu_ula_param #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IMM_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic [WIDTH-1:0] op_result,
   output logic             done,
   output logic             busy,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_ADDI = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_SUBI = 4'b0100;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_SHL  = 4'b1001;
   localparam logic [3:0] OP_SHR  = 4'b1010;

   typedef enum logic [1:0] {IDLE, CALC, MULT, FINISH} state_t;

   state_t             state, state_nxt;
   logic               legal, accept, calc_we, mul_we, done_d;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [SW-1:0]      cnt;

   logic [WIDTH-1:0]   imm, opnd, alu_res;
   logic               do_sub, is_arith, alu_c, alu_v;
   logic [WIDTH:0]     sum, shl_w;
   logic [SW-1:0]      shamt;

   always_comb legal = (op_code >= OP_ADD) && (op_code <= OP_SHR);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && legal) state_nxt = (op_code == OP_MUL) ? MULT : CALC;
         CALC:    state_nxt = FINISH;
         MULT:    if (cnt == CNT_LAST) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy    = (state != IDLE);
      accept  = (state == IDLE) && start && legal;
      calc_we = (state == CALC);
      mul_we  = (state == MULT) && (cnt == CNT_LAST);
      done_d  = (state == FINISH);
   end

   always_comb acc_nxt = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      imm      = {{(WIDTH-IMM_W+1){1'b0}}, b_q[IMM_W-2:0]};
      opnd     = b_q;
      do_sub   = 1'b0;
      is_arith = 1'b1;
      case (op_q)
         OP_ADD:  ;
         OP_SUB:  do_sub = 1'b1;
         OP_ADDI: begin opnd = imm; do_sub = b_q[IMM_W-1];  end
         OP_SUBI: begin opnd = imm; do_sub = ~b_q[IMM_W-1]; end
         default: is_arith = 1'b0;
      endcase
      // One extra bit: carry-out on add, borrow on subtract
      sum   = do_sub ? ({1'b0, a_q} - {1'b0, opnd}) : ({1'b0, a_q} + {1'b0, opnd});
      shamt = b_q[SW-1:0];
      shl_w = {1'b0, a_q} << shamt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      if (is_arith) begin
         alu_res = sum[WIDTH-1:0];
         alu_c   = sum[WIDTH];
         alu_v   = (do_sub ? (a_q[WIDTH-1] != opnd[WIDTH-1]) : (a_q[WIDTH-1] == opnd[WIDTH-1]))
                   && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end else begin
         case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHL:  begin alu_res = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; end
            OP_SHR:  alu_res = a_q >> shamt;
            default: alu_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         op_result <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= done_d;
         if (accept) begin
            op_q   <= op_code;
            a_q    <= src1;
            b_q    <= src2;
            mcand  <= {{WIDTH{1'b0}}, src1};
            mplier <= src2;
            acc    <= '0;
            cnt    <= '0;
         end
         if (state == MULT) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SW'(1);
         end
         if (calc_we) begin
            op_result <= alu_res;
            zero      <= (alu_res == '0);
            carry     <= alu_c;
            overflow  <= alu_v;
         end else if (mul_we) begin
            op_result <= acc_nxt[WIDTH-1:0];
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            carry     <= 1'b0;
            overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
         end
      end
   end

endmodule
